// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Monitors a RISC-V core's data-memory write port and compares each store
//   against a programmable, strictly ordered table of expected address/data
//   pairs. Stores into a scratch address window are tolerated. The outcome is
//   reported through sticky status registers.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   exp_we/exp_idx/
//   exp_addr/exp_data     : expected-table write (only when not ARMED)
//   exp_count             : number of valid entries, sampled on start
//   start                 : arm the checker (ignored while ARMED)
//   MemWrite/DataAdr/
//   WriteData             : monitored core store port
//   armed                 : checker is in ARMED
//   done/pass/fail_code   : sticky outcome (01 data, 10 address, 11 timeout)
//   check_idx             : entries matched so far
//   cycle_count           : ARMED edges elapsed
//   fail_addr/fail_data   : the offending store (0 on timeout)
module mem_write_checker #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_CHECKS   = 4,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned SCRATCH_BASE = 96,
    parameter int unsigned SCRATCH_SIZE = 4,
    localparam int unsigned IDX_W       = $clog2(NUM_CHECKS + 1),
    localparam int unsigned CNT_W       = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IDX_W-1:0]  exp_count,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              armed,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  check_idx,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0]  SCR_LO  = (ADDR_W + 1)'(SCRATCH_BASE);
    localparam logic [ADDR_W:0]  SCR_HI  = SCR_LO + (ADDR_W + 1)'(SCRATCH_SIZE);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    check_idx_q, check_idx_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [1:0]          fail_code_q, fail_code_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_data_q, fail_data_d;
    logic [ADDR_W-1:0]   tbl_addr_q [NUM_CHECKS];
    logic [ADDR_W-1:0]   tbl_addr_d [NUM_CHECKS];
    logic [DATA_W-1:0]   tbl_data_q [NUM_CHECKS];
    logic [DATA_W-1:0]   tbl_data_d [NUM_CHECKS];

    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;
    logic [IDX_W-1:0]    count_in;
    logic                addr_hit;
    logic                data_hit;
    logic                in_scratch;

    // Entry currently awaited; indices past the table read as zero.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
            if (check_idx_q == IDX_W'(i)) begin
                cur_addr = tbl_addr_q[i];
                cur_data = tbl_data_q[i];
            end
        end
    end

    assign addr_hit   = MemWrite && (DataAdr == cur_addr);
    assign data_hit   = (WriteData == cur_data);
    assign in_scratch = ({1'b0, DataAdr} >= SCR_LO) && ({1'b0, DataAdr} < SCR_HI);

    always_comb begin
        count_in = exp_count;
        if (exp_count == '0) begin
            count_in = IDX_W'(1);
        end else if (exp_count > MAX_CNT) begin
            count_in = MAX_CNT;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        check_idx_d   = check_idx_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_code_d   = fail_code_q;
        fail_addr_d   = fail_addr_q;
        fail_data_d   = fail_data_q;
        tbl_addr_d    = tbl_addr_q;
        tbl_data_d    = tbl_data_q;

        case (state_q)
            S_ARMED: begin
                if (addr_hit && data_hit) begin
                    check_idx_d = check_idx_q + IDX_W'(1);
                    if (check_idx_d == count_q) begin
                        state_d = S_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end else if (addr_hit) begin
                    state_d     = S_FAIL;
                    done_d      = 1'b1;
                    fail_code_d = 2'b01;
                    fail_addr_d = DataAdr;
                    fail_data_d = WriteData;
                end else if (MemWrite && !in_scratch) begin
                    state_d     = S_FAIL;
                    done_d      = 1'b1;
                    fail_code_d = 2'b10;
                    fail_addr_d = DataAdr;
                    fail_data_d = WriteData;
                end

                // A write outcome decided above wins over the timeout; on the
                // timeout edge itself the counter holds at TIMEOUT-1.
                if (state_d == S_ARMED && cycle_count_q == TO_LAST) begin
                    state_d     = S_TOUT;
                    done_d      = 1'b1;
                    fail_code_d = 2'b11;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
            end

            default: begin
                if (exp_we) begin
                    for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                        if (exp_idx == IDX_W'(i)) begin
                            tbl_addr_d[i] = exp_addr;
                            tbl_data_d[i] = exp_data;
                        end
                    end
                end
                if (start) begin
                    state_d       = S_ARMED;
                    count_d       = count_in;
                    check_idx_d   = '0;
                    cycle_count_d = '0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    fail_code_d   = 2'b00;
                    fail_addr_d   = '0;
                    fail_data_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            check_idx_q   <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= 2'b00;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
            for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            check_idx_q   <= check_idx_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_code_q   <= fail_code_d;
            fail_addr_q   <= fail_addr_d;
            fail_data_q   <= fail_data_d;
            tbl_addr_q    <= tbl_addr_d;
            tbl_data_q    <= tbl_data_d;
        end
    end

    assign armed       = (state_q == S_ARMED);
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign check_idx   = check_idx_q;
    assign cycle_count = cycle_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

    localparam int TMO = 8;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        exp_we;
    logic [2:0]  exp_idx;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
    logic        start;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        armed;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [2:0]  check_idx;
    logic [3:0]  cycle_count;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;

    int checks = 0;
    int errors = 0;

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(NCH), .TIMEOUT(TMO),
        .SCRATCH_BASE(96), .SCRATCH_SIZE(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_count(exp_count), .start(start),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .armed(armed), .done(done), .pass(pass), .fail_code(fail_code),
        .check_idx(check_idx), .cycle_count(cycle_count),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    // Reference model: the checker's contract expressed as plain variables.
    bit          m_armed, m_done, m_pass;
    int          m_code, m_idx, m_cyc, m_cnt;
    logic [31:0] m_faddr, m_fdata;
    logic [31:0] m_taddr [NCH];
    logic [31:0] m_tdata [NCH];

    task automatic model_reset();
        m_armed = 0; m_done = 0; m_pass = 0;
        m_code = 0; m_idx = 0; m_cyc = 0; m_cnt = 0;
        m_faddr = 0; m_fdata = 0;
        for (int i = 0; i < NCH; i++) begin
            m_taddr[i] = 0;
            m_tdata[i] = 0;
        end
    endtask

    task automatic model_fail(input int code);
        m_armed = 0; m_done = 1; m_code = code;
        m_faddr = DataAdr; m_fdata = WriteData;
    endtask

    // Applies the currently driven inputs as one clock edge.
    task automatic model_step();
        bit ended;
        if (m_armed) begin
            ended = 0;
            if (MemWrite && m_idx < NCH && DataAdr == m_taddr[m_idx]) begin
                if (WriteData == m_tdata[m_idx]) begin
                    m_idx = m_idx + 1;
                    if (m_idx == m_cnt) begin
                        m_armed = 0; m_done = 1; m_pass = 1; ended = 1;
                    end
                end else begin
                    model_fail(1); ended = 1;
                end
            end else if (MemWrite && !(DataAdr >= 96 && DataAdr < 100)) begin
                model_fail(2); ended = 1;
            end
            if (!ended && m_cyc == TMO - 1) begin
                m_armed = 0; m_done = 1; m_code = 3;
                m_faddr = 0; m_fdata = 0;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end else begin
            if (exp_we && int'(exp_idx) < NCH) begin
                m_taddr[exp_idx] = exp_addr;
                m_tdata[exp_idx] = exp_data;
            end
            if (start) begin
                m_cnt = (exp_count == 0) ? 1 : (int'(exp_count) > NCH ? NCH : int'(exp_count));
                m_armed = 1; m_done = 0; m_pass = 0; m_code = 0;
                m_idx = 0; m_cyc = 0; m_faddr = 0; m_fdata = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1; exp_idx = idx; exp_addr = a; exp_data = d;
        tick();
        exp_we = 0;
    endtask

    task automatic arm(input logic [2:0] cnt);
        start = 1; exp_count = cnt;
        tick();
        start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #1;
        checks++;
        if ({armed, done, pass, fail_code, check_idx, cycle_count, fail_addr, fail_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got armed=%0b done=%0b pass=%0b code=%0d idx=%0d cyc=%0d want all 0",
                     armed, done, pass, fail_code, check_idx, cycle_count);
        end
        tick(); tick();
        reset_n = 1;
        tick();
        checks++;
        if (armed !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got armed=%0b done=%0b want 0 0", armed, done);
        end
    endtask

    task automatic test_pass_scratch();
        prog(0, 100, 25);
        arm(1);
        checks++;
        if (armed !== 1'b1 || cycle_count !== 4'd0 || check_idx !== 3'd0) begin
            errors++; $display("FAIL arm_state: got armed=%0b cyc=%0d idx=%0d want 1 0 0", armed, cycle_count, check_idx);
        end
        wr(96, 7);
        checks++;
        if (done !== 1'b0 || check_idx !== 3'd0 || cycle_count !== 4'd1) begin
            errors++; $display("FAIL scratch_ignored: got done=%0b idx=%0d cyc=%0d want 0 0 1", done, check_idx, cycle_count);
        end
        wr(100, 25);
        checks++;
        if (pass !== 1'b1 || done !== 1'b1 || fail_code !== 2'b00 || check_idx !== 3'd1 || armed !== 1'b0) begin
            errors++; $display("FAIL pass_scratch: got pass=%0b done=%0b code=%0d idx=%0d armed=%0b want 1 1 0 1 0",
                               pass, done, fail_code, check_idx, armed);
        end
    endtask

    task automatic test_mismatch();
        arm(1);
        wr(100, 24);
        checks++;
        if (fail_code !== 2'b01 || fail_addr !== 32'd100 || fail_data !== 32'd24 || pass !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL data_mismatch: got code=%0d addr=%0d data=%0d pass=%0b done=%0b want 1 100 24 0 1",
                               fail_code, fail_addr, fail_data, pass, done);
        end
    endtask

    task automatic test_unexpected();
        prog(0, 32'h10, 1);
        prog(1, 32'h14, 2);
        arm(2);
        wr(32'h14, 2);
        checks++;
        if (fail_code !== 2'b10 || check_idx !== 3'd0 || fail_addr !== 32'h14 || fail_data !== 32'd2) begin
            errors++; $display("FAIL out_of_order: got code=%0d idx=%0d addr=%0h data=%0d want 2 0 14 2",
                               fail_code, check_idx, fail_addr, fail_data);
        end
    endtask

    task automatic test_order();
        arm(2);
        wr(32'h10, 1);
        checks++;
        if (check_idx !== 3'd1 || done !== 1'b0 || armed !== 1'b1) begin
            errors++; $display("FAIL first_match: got idx=%0d done=%0b armed=%0b want 1 0 1", check_idx, done, armed);
        end
        wr(32'h14, 2);
        checks++;
        if (pass !== 1'b1 || check_idx !== 3'd2 || fail_code !== 2'b00) begin
            errors++; $display("FAIL ordered_pass: got pass=%0b idx=%0d code=%0d want 1 2 0", pass, check_idx, fail_code);
        end
    endtask

    task automatic test_timeout();
        arm(1);
        for (int i = 0; i < TMO - 1; i++) tick();
        checks++;
        if (done !== 1'b0 || cycle_count !== 4'd7 || armed !== 1'b1) begin
            errors++; $display("FAIL pre_timeout: got done=%0b cyc=%0d armed=%0b want 0 7 1", done, cycle_count, armed);
        end
        tick();
        checks++;
        if (done !== 1'b1 || fail_code !== 2'b11 || cycle_count !== 4'd7 || armed !== 1'b0 || fail_addr !== 32'd0) begin
            errors++; $display("FAIL timeout: got done=%0b code=%0d cyc=%0d armed=%0b addr=%0d want 1 3 7 0 0",
                               done, fail_code, cycle_count, armed, fail_addr);
        end
        wr(32'h10, 1);
        checks++;
        if (fail_code !== 2'b11 || check_idx !== 3'd0 || pass !== 1'b0) begin
            errors++; $display("FAIL terminal_hold: got code=%0d idx=%0d pass=%0b want 3 0 0", fail_code, check_idx, pass);
        end
        arm(1);
        for (int i = 0; i < TMO - 1; i++) tick();
        wr(32'h10, 1);
        checks++;
        if (pass !== 1'b1 || fail_code !== 2'b00 || check_idx !== 3'd1) begin
            errors++; $display("FAIL pass_on_timeout_edge: got pass=%0b code=%0d idx=%0d want 1 0 1", pass, fail_code, check_idx);
        end
        arm(1);
        for (int i = 0; i < TMO - 1; i++) tick();
        wr(32'h40, 3);
        checks++;
        if (fail_code !== 2'b10 || fail_addr !== 32'h40) begin
            errors++; $display("FAIL fail_on_timeout_edge: got code=%0d addr=%0h want 2 40", fail_code, fail_addr);
        end
    endtask

    task automatic test_reset_rearm();
        prog(0, 32'h20, 5);
        prog(1, 32'h24, 6);
        arm(2);
        wr(32'h20, 5);
        start = 1; exp_count = 1;
        tick();
        start = 0;
        checks++;
        if (check_idx !== 3'd1 || cycle_count !== 4'd2 || armed !== 1'b1) begin
            errors++; $display("FAIL start_while_armed: got idx=%0d cyc=%0d armed=%0b want 1 2 1", check_idx, cycle_count, armed);
        end
        #1 reset_n = 0;
        #1;
        checks++;
        if ({armed, done, pass, fail_code, check_idx, cycle_count, fail_addr, fail_data} !== '0) begin
            errors++; $display("FAIL async_abort: got armed=%0b idx=%0d cyc=%0d want all 0", armed, check_idx, cycle_count);
        end
        #1 reset_n = 1;
        arm(1);
        wr(32'h0, 32'h0);
        checks++;
        if (pass !== 1'b1) begin
            errors++; $display("FAIL table_cleared: got pass=%0b code=%0d want pass 1", pass, fail_code);
        end
        prog(0, 32'h30, 9);
        arm(1);
        wr(32'h30, 9);
        checks++;
        if (pass !== 1'b1 || check_idx !== 3'd1) begin
            errors++; $display("FAIL rearm_pass: got pass=%0b idx=%0d want 1 1", pass, check_idx);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        pool = '{32'h10, 32'h14, 32'h18, 32'h1c, 32'd96, 32'd99, 32'd100, 32'h0};
        reset_n = 0;
        #1 reset_n = 1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            start     = ($urandom_range(0, 7) == 0);
            exp_count = 3'($urandom_range(0, 6));
            exp_we    = ($urandom_range(0, 3) == 0);
            exp_idx   = 3'($urandom_range(0, 5));
            exp_addr  = pool[$urandom_range(0, 7)];
            exp_data  = $urandom_range(0, 3);
            MemWrite  = ($urandom_range(0, 1) == 1);
            if (m_idx < NCH && $urandom_range(0, 1) == 1) DataAdr = m_taddr[m_idx];
            else DataAdr = pool[$urandom_range(0, 7)];
            if (m_idx < NCH && $urandom_range(0, 9) < 7) WriteData = m_tdata[m_idx];
            else WriteData = $urandom_range(0, 3);
            model_step();
            tick();
            checks++;
            if (armed !== m_armed) begin errors++; $display("FAIL rnd_armed @%0d: got %0b want %0b", n, armed, m_armed); end
            checks++;
            if (done !== m_done) begin errors++; $display("FAIL rnd_done @%0d: got %0b want %0b", n, done, m_done); end
            checks++;
            if (pass !== m_pass) begin errors++; $display("FAIL rnd_pass @%0d: got %0b want %0b", n, pass, m_pass); end
            checks++;
            if (fail_code !== 2'(m_code)) begin errors++; $display("FAIL rnd_code @%0d: got %0d want %0d", n, fail_code, m_code); end
            checks++;
            if (check_idx !== 3'(m_idx)) begin errors++; $display("FAIL rnd_idx @%0d: got %0d want %0d", n, check_idx, m_idx); end
            checks++;
            if (cycle_count !== 4'(m_cyc)) begin errors++; $display("FAIL rnd_cyc @%0d: got %0d want %0d", n, cycle_count, m_cyc); end
            checks++;
            if (fail_addr !== m_faddr || fail_data !== m_fdata) begin
                errors++; $display("FAIL rnd_fail_bus @%0d: got %0h/%0h want %0h/%0h", n, fail_addr, fail_data, m_faddr, m_fdata);
            end
        end
        start = 0; exp_we = 0; MemWrite = 0;
    endtask

    initial begin
        exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0; exp_count = 0;
        start = 0; MemWrite = 0; DataAdr = 0; WriteData = 0;
        test_reset();
        test_pass_scratch();
        test_mismatch();
        test_unexpected();
        test_order();
        test_timeout();
        test_reset_rearm();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

- Synthesisable self-checking monitor for single-cycle and multi-cycle RISC-V cores.
- Watches the core's data-memory write port (MemWrite, DataAdr, WriteData) and compares write events against a programmable table of up to NUM_CHECKS expected address/data pairs. Writes to a scratch address window are tolerated.
- Reports pass, fail cause or timeout through sticky status registers.
- Sits beside the core in `top`-level simulation and FPGA builds. It replaces hand-written per-program checks in benches.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_CHECKS, 4, expected-table depth (1..16); IDX_W = $clog2(NUM_CHECKS+1)
- TIMEOUT, 1000, max cycles in ARMED before timeout (≥2); CNT_W = $clog2(TIMEOUT+1)
- SCRATCH_BASE, 96, first tolerated scratch address
- SCRATCH_SIZE, 4, scratch window size in bytes (0 disables)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - reset_n  in  1  asynchronous active-low reset
- Table programming:
  - exp_we  in  1  write expected-table entry
  - exp_idx  in  IDX_W  table entry index
  - exp_addr  in  ADDR_W  expected write address
  - exp_data  in  DATA_W  expected write data
  - exp_count  in  IDX_W  number of valid entries (1..NUM_CHECKS), sampled on start
- Control and monitored bus:
  - start  in  1  arm checker (pulse)
  - MemWrite  in  1  core store strobe
  - DataAdr  in  ADDR_W  core store address
  - WriteData  in  DATA_W  core store data
- Status outputs:
  - armed  out  1  checker in ARMED
  - done  out  1  sticky: terminal state reached
  - pass  out  1  sticky: all expected writes seen in order
  - fail_code  out  2  00 none, 01 data mismatch, 10 unexpected address, 11 timeout
  - check_idx  out  IDX_W  entries matched so far
  - cycle_count  out  CNT_W  cycles spent in ARMED
  - fail_addr  out  ADDR_W  DataAdr of failing write (0 on timeout)
  - fail_data  out  DATA_W  WriteData of failing write (0 on timeout)

## Operation
- States:
  - IDLE: reset state.
  - ARMED
  - PASS, FAIL, TOUT: terminal states.
- Table writes:
  - exp_we writes table[exp_idx] in IDLE and terminal states.
  - Ignored in ARMED.
  - Ignored if exp_idx ≥ NUM_CHECKS.
- start:
  - In any non-ARMED state: latches exp_count (clamped to 1..NUM_CHECKS), clears check_idx, cycle_count, fail_*, done, pass and fail_code, then enters ARMED.
  - In ARMED: start is ignored.
- ARMED, each cycle:
  - cycle_count increments (saturating).
  - If MemWrite is high, write priority is:
    1. DataAdr == table[check_idx].addr and WriteData == its data: check_idx+1. If the new value equals the latched count, go to PASS.
    2. DataAdr == table[check_idx].addr, data differs: FAIL, code 01.
    3. DataAdr in [SCRATCH_BASE, SCRATCH_BASE+SCRATCH_SIZE): ignored.
    4. Otherwise: FAIL, code 10; capture DataAdr/WriteData.
  - Matching is strictly ordered; a later table entry's address counts as unexpected.
  - If no transition occurs and cycle_count == TIMEOUT-1: go to TOUT, code 11.
- Simultaneous events:
  - A final matching write in the timeout cycle yields PASS.
  - A failing write in the timeout cycle yields FAIL with that write's code.
- Terminal states hold all status until start or reset; MemWrite is ignored.
- Width rules: address and data compares are full-width exact; X/Z handling is simulation-only and not part of the contract.

## Timing
- Reset (async assert, sync release) gives:
  - state IDLE
  - all outputs 0
  - table contents 0
- start sampled at edge N:
  - armed=1 and counters cleared after edge N.
  - The first write can be checked at edge N+1.
- A write event sampled at edge N updates check_idx, done, pass, fail_* after edge N (registered, one-edge latency).
- In ARMED:
  - cycle_count equals the number of ARMED edges elapsed.
  - TOUT is entered on the edge where cycle_count reaches TIMEOUT-1, giving done=1 after exactly TIMEOUT ARMED edges.
- reset_n asserted mid-ARMED aborts immediately: outputs 0, table cleared.
- done, pass and fail_code change only on the transition edge; armed = (state==ARMED).

## Test plan
- Pass with scratch write:
  - Stimulus: table {(100,25)}, count 1; start; writes (96,7) then (100,25).
  - Required: pass=1, done=1, fail_code=00, check_idx=1.
- Data mismatch:
  - Stimulus: table {(100,25)}; write (100,24).
  - Required: fail_code=01, fail_addr=100, fail_data=24, pass=0.
- Ordered sequence, then unexpected address:
  - Stimulus: table {(0x10,1),(0x14,2)}, count 2; write (0x14,2) first.
  - Required: fail_code=10, check_idx=0.
- Ordered sequence, correct order:
  - Stimulus: same table; writes (0x10,1), (0x14,2).
  - Required: pass after the second write.
- Timeout:
  - Stimulus: TIMEOUT=8; start with no writes.
  - Required: done=1 and fail_code=11 after exactly 8 ARMED edges, cycle_count=7. A final matching write on edge 8 gives pass instead.
- Reset and re-arm:
  - Stimulus: assert reset_n low mid-ARMED.
  - Required: all outputs 0 asynchronously.
  - Stimulus: reprogram table, start again.
  - Required: new run passes. start while ARMED leaves check_idx and cycle_count unchanged.
